// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if
// Bundles the signals between the multicycle MIPS control unit and its datapath.
//   master : control unit side (takes op/funct/zero/mem_ready, drives every control)
//   slave  : datapath side (mirror image of master)
// CNT_W sets the width of the retired-instruction counter and must match the
// controller's CNT_W.
interface mips_multicycle_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             iord;
    logic             memwrite;
    logic             irwrite;
    logic             regdst;
    logic             memtoreg;
    logic             regwrite;
    logic             alusrca;
    logic             branch;
    logic [1:0]       alusrcb;
    logic [1:0]       pcsrc;
    logic [2:0]       alucontrol;
    logic             pcen;
    logic             instr_done;
    logic [CNT_W-1:0] retired;
    logic             illegal;
    logic [3:0]       state;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, branch, alusrcb, pcsrc, alucontrol, pcen, instr_done,
               retired, illegal, state
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, branch, alusrcb, pcsrc, alucontrol, pcen, instr_done,
               retired, illegal, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Moore-style multicycle MIPS control unit (LW, SW, R-type, BEQ, ADDI, J) for a
// shared-memory datapath, with a memory ready handshake and a retired counter.
// Ports:
//   clock     rising-edge clock
//   reset     synchronous, active-high
//   bus       mips_multicycle_ctrl_if.master: op/funct/zero/mem_ready in,
//             datapath controls, pcen, instr_done, retired, illegal, state out
// Parameters:
//   CNT_W          retired counter width (wraps modulo 2^CNT_W)
//   MEM_HANDSHAKE  1: FETCH/MEMRD/MEMWR wait for mem_ready; 0: mem_ready ignored
// Build option:
//   MIPS_MC_ILLEGAL_TRAP_EN  defined: undefined opcodes lock into TRAP until
//   reset with illegal=1; undefined: they retire as a NOP from DECODE.
module mips_multicycle_ctrl #(
    parameter int CNT_W         = 16,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input logic                   clock,
    input logic                   reset,
    mips_multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11,
        TRAP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t           state_q;
    state_t           state_d;
    state_t           out_state;
    logic [CNT_W-1:0] retired_q;
    logic             ready;
    logic [1:0]       aluop;
    logic             pcwrite;
    logic             mem_req, iord, memwrite, irwrite, regdst, memtoreg;
    logic             regwrite, alusrca, branch, pcen, instr_done, illegal;
    logic [1:0]       alusrcb, pcsrc;
    logic [2:0]       alucontrol;

    assign ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (instr_done) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (ready) state_d = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYP:      state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
                    default:      state_d = TRAP;
`else
                    default:      state_d = FETCH;
`endif
                endcase
            end
            MEMADR:  state_d = (bus.op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (ready) state_d = MEMWB;
            MEMWR:   if (ready) state_d = FETCH;
            EXECUTE: state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: state_d = FETCH;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
            TRAP:    state_d = TRAP;
`else
            TRAP:    state_d = FETCH;
`endif
            default: state_d = FETCH;
        endcase
    end

    // While reset is high the outputs are those of FETCH so a half-finished
    // instruction cannot leak controls; all state-committing strobes are then
    // forced low below.
    assign out_state = reset ? FETCH : state_q;

    always_comb begin
        mem_req  = 1'b0;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        branch   = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 2'b00;
        pcwrite  = 1'b0;
        case (out_state)
            FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                irwrite = ready;
                pcwrite = ready;
            end
            DECODE:  alusrcb = 2'b11;
            MEMADR, ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            ADDIWB:  regwrite = 1'b1;
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                branch  = 1'b1;
                pcsrc   = 2'b01;
            end
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
        end
    end

    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (bus.funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    assign pcen       = pcwrite | (branch & bus.zero);
    assign instr_done = !reset && (state_q != FETCH) && (state_d == FETCH);
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
    assign illegal    = !reset && (state_q == TRAP);
`else
    assign illegal    = 1'b0;
`endif

    assign bus.mem_req    = mem_req;
    assign bus.iord       = iord;
    assign bus.memwrite   = memwrite;
    assign bus.irwrite    = irwrite;
    assign bus.regdst     = regdst;
    assign bus.memtoreg   = memtoreg;
    assign bus.regwrite   = regwrite;
    assign bus.alusrca    = alusrca;
    assign bus.branch     = branch;
    assign bus.alusrcb    = alusrcb;
    assign bus.pcsrc      = pcsrc;
    assign bus.alucontrol = alucontrol;
    assign bus.pcen       = pcen;
    assign bus.instr_done = instr_done;
    assign bus.retired    = retired_q;
    assign bus.illegal    = illegal;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
// Directed bench for mips_multicycle_ctrl. dut0: CNT_W=16, MEM_HANDSHAKE=1.
// dut1: CNT_W=4, MEM_HANDSHAKE=0. Each instruction pushes its expected
// per-cycle state/controls into a queue; the queue is then drained one cycle
// per entry and compared against the selected DUT. The idle DUT is held in reset.
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                           S_MEMRD = 4'd3, S_MEMWB = 4'd4, S_MEMWR = 4'd5,
                           S_EXEC = 4'd6, S_ALUWB = 4'd7, S_BRANCH = 4'd8,
                           S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_JUMP = 4'd11,
                           S_TRAP = 4'd12;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [18:0] ctrl;
        logic        drv;
        logic        rst;
        logic        done;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset0, reset1;
    logic [5:0] op, funct;
    logic       zero, mem_ready;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   ret_m0  = 0;
    int   ret_m1  = 0;

    always #5 clock = ~clock;

    mips_multicycle_ctrl_if #(.CNT_W(16)) bus0 ();
    mips_multicycle_ctrl_if #(.CNT_W(4))  bus1 ();

    assign bus0.op = op;  assign bus0.funct = funct;
    assign bus0.zero = zero;  assign bus0.mem_ready = mem_ready;
    assign bus1.op = op;  assign bus1.funct = funct;
    assign bus1.zero = zero;  assign bus1.mem_ready = mem_ready;

    mips_multicycle_ctrl #(.CNT_W(16), .MEM_HANDSHAKE(1'b1)) dut0 (
        .clock(clock), .reset(reset0), .bus(bus0.master)
    );
    mips_multicycle_ctrl #(.CNT_W(4), .MEM_HANDSHAKE(1'b0)) dut1 (
        .clock(clock), .reset(reset1), .bus(bus1.master)
    );

    // Expected controls per state, straight from the state/control table.
    function automatic logic [18:0] spec_ctrl(logic [3:0] st, logic r, logic z,
                                              logic [2:0] a, logic done);
        logic mreq = 0, iord = 0, mw = 0, irw = 0, rdst = 0, m2r = 0, rw = 0;
        logic asa = 0, br = 0, pcen = 0, ill = 0;
        logic [1:0] asb = 2'b00, psrc = 2'b00;
        logic [2:0] aluc = 3'b010;
        case (st)
            S_FETCH:  begin mreq = 1; asb = 2'b01; irw = r; pcen = r; end
            S_DECODE: asb = 2'b11;
            S_MEMADR, S_ADDIEX: begin asa = 1; asb = 2'b10; end
            S_MEMRD:  begin mreq = 1; iord = 1; end
            S_MEMWB:  begin m2r = 1; rw = 1; end
            S_MEMWR:  begin mreq = 1; iord = 1; mw = 1; end
            S_EXEC:   begin asa = 1; aluc = a; end
            S_ALUWB:  begin rdst = 1; rw = 1; end
            S_ADDIWB: rw = 1;
            S_BRANCH: begin asa = 1; br = 1; psrc = 2'b01; aluc = 3'b110; pcen = z; end
            S_JUMP:   begin psrc = 2'b10; pcen = 1; end
            S_TRAP:   ill = 1;
            default: ;
        endcase
        return {mreq, iord, mw, irw, rdst, m2r, rw, asa, br, asb, psrc, aluc,
                pcen, done, ill};
    endfunction

    function automatic logic [18:0] obs_ctrl(int sel);
        if (sel == 0)
            return {bus0.mem_req, bus0.iord, bus0.memwrite, bus0.irwrite, bus0.regdst,
                    bus0.memtoreg, bus0.regwrite, bus0.alusrca, bus0.branch, bus0.alusrcb,
                    bus0.pcsrc, bus0.alucontrol, bus0.pcen, bus0.instr_done, bus0.illegal};
        return {bus1.mem_req, bus1.iord, bus1.memwrite, bus1.irwrite, bus1.regdst,
                bus1.memtoreg, bus1.regwrite, bus1.alusrca, bus1.branch, bus1.alusrcb,
                bus1.pcsrc, bus1.alucontrol, bus1.pcen, bus1.instr_done, bus1.illegal};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push(string tag, logic [3:0] st_reg, logic [3:0] st_ctrl, logic drv,
                        logic r, logic [2:0] a, logic done, logic rst);
        exp_t e;
        e.tag  = tag;
        e.st   = st_reg;
        e.ctrl = spec_ctrl(st_ctrl, r, zero, a, done);
        e.drv  = drv;
        e.rst  = rst;
        e.done = done;
        q.push_back(e);
    endtask

    // A ready-gated state: with the handshake, w stall cycles then the
    // completing cycle; without it, one cycle with mem_ready driven low anyway.
    task automatic push_mem(string tag, logic [3:0] st, int w, bit hs, logic fin_done);
        if (hs) begin
            for (int i = 0; i < w; i++) push(tag, st, st, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0);
            push(tag, st, st, 1'b1, 1'b1, 3'b010, fin_done, 1'b0);
        end else begin
            push(tag, st, st, (w > 0) ? 1'b0 : 1'b1, 1'b1, 3'b010, fin_done, 1'b0);
        end
    endtask

    task automatic drain(int sel);
        exp_t e;
        int   exp_ret;
        while (q.size() > 0) begin
            e = q.pop_front();
            mem_ready = e.drv;
            if (sel == 0) begin reset0 = e.rst; reset1 = 1'b1; end
            else          begin reset1 = e.rst; reset0 = 1'b1; end
            exp_ret = (sel == 0) ? ret_m0 : ret_m1;
            @(negedge clock);
            check({e.tag, "_state"}, 32'((sel == 0) ? bus0.state : bus1.state), 32'(e.st));
            check({e.tag, "_ctrl"}, 32'(obs_ctrl(sel)), 32'(e.ctrl));
            check({e.tag, "_retired"},
                  (sel == 0) ? 32'(bus0.retired) : 32'(bus1.retired), 32'(exp_ret));
            @(posedge clock);
            #1;
            if (sel == 0) ret_m0 = e.rst ? 0 : (e.done ? ((ret_m0 + 1) & 16'hFFFF) : ret_m0);
            else          ret_m1 = e.rst ? 0 : (e.done ? ((ret_m1 + 1) & 4'hF) : ret_m1);
        end
    endtask

    task automatic run(int sel, string tag, logic [5:0] o, logic [5:0] f, logic z,
                       int fw, int mw, logic [2:0] a);
        bit   hs = (sel == 0);
        logic known;
        op    = o;
        funct = f;
        zero  = z;
        known = (o == OP_LW) || (o == OP_SW) || (o == OP_RTYP) || (o == OP_BEQ) ||
                (o == OP_ADDI) || (o == OP_J);
        push_mem({tag, "_fetch"}, S_FETCH, fw, hs, 1'b0);
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
        push({tag, "_decode"}, S_DECODE, S_DECODE, 1'b1, 1'b1, 3'b010, 1'b0, 1'b0);
`else
        push({tag, "_decode"}, S_DECODE, S_DECODE, 1'b1, 1'b1, 3'b010, !known, 1'b0);
`endif
        case (o)
            OP_LW: begin
                push({tag, "_memadr"}, S_MEMADR, S_MEMADR, 1, 1, 3'b010, 0, 0);
                push_mem({tag, "_memrd"}, S_MEMRD, mw, hs, 1'b0);
                push({tag, "_memwb"}, S_MEMWB, S_MEMWB, 1, 1, 3'b010, 1, 0);
            end
            OP_SW: begin
                push({tag, "_memadr"}, S_MEMADR, S_MEMADR, 1, 1, 3'b010, 0, 0);
                push_mem({tag, "_memwr"}, S_MEMWR, mw, hs, 1'b1);
            end
            OP_RTYP: begin
                push({tag, "_exec"}, S_EXEC, S_EXEC, 1, 1, a, 0, 0);
                push({tag, "_aluwb"}, S_ALUWB, S_ALUWB, 1, 1, 3'b010, 1, 0);
            end
            OP_BEQ:  push({tag, "_branch"}, S_BRANCH, S_BRANCH, 1, 1, 3'b010, 1, 0);
            OP_ADDI: begin
                push({tag, "_addiex"}, S_ADDIEX, S_ADDIEX, 1, 1, 3'b010, 0, 0);
                push({tag, "_addiwb"}, S_ADDIWB, S_ADDIWB, 1, 1, 3'b010, 1, 0);
            end
            OP_J:    push({tag, "_jump"}, S_JUMP, S_JUMP, 1, 1, 3'b010, 1, 0);
            default: begin
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
                for (int i = 0; i < 4; i++)
                    push({tag, "_trap"}, S_TRAP, S_TRAP, 1, 1, 3'b010, 0, 0);
                push({tag, "_trap_rst"}, S_TRAP, S_FETCH, 1, 0, 3'b010, 0, 1);
`endif
            end
        endcase
        drain(sel);
    endtask

    initial begin
        reset0    = 1'b1;
        reset1    = 1'b1;
        op        = OP_J;
        funct     = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clock);
        #1;
        // Reset cycle with ready high: FETCH outputs but no irwrite/pcen.
        push("reset", S_FETCH, S_FETCH, 1'b1, 1'b0, 3'b010, 1'b0, 1'b1);
        drain(0);

        run(0, "lw",      OP_LW,   6'b000000, 0, 0, 0, 3'b010);
        run(0, "slt",     OP_RTYP, 6'b101010, 0, 0, 0, 3'b111);
        run(0, "add",     OP_RTYP, 6'b100000, 0, 0, 0, 3'b010);
        run(0, "sub",     OP_RTYP, 6'b100010, 1, 0, 0, 3'b110);
        run(0, "and",     OP_RTYP, 6'b100100, 0, 0, 0, 3'b000);
        run(0, "or",      OP_RTYP, 6'b100101, 0, 0, 0, 3'b001);
        run(0, "badfn",   OP_RTYP, 6'b111111, 0, 0, 0, 3'b010);
        run(0, "beq_z1",  OP_BEQ,  6'b000000, 1, 0, 0, 3'b010);
        run(0, "beq_z0",  OP_BEQ,  6'b000000, 0, 0, 0, 3'b010);
        run(0, "addi",    OP_ADDI, 6'b000000, 0, 0, 0, 3'b010);
        run(0, "j",       OP_J,    6'b000000, 0, 0, 0, 3'b010);
        run(0, "sw_wait", OP_SW,   6'b000000, 0, 0, 3, 3'b010);
        run(0, "lw_wait", OP_LW,   6'b000000, 0, 1, 2, 3'b010);
        run(0, "illegal", OP_BAD,  6'b000000, 0, 0, 0, 3'b010);
        run(0, "j_after", OP_J,    6'b000000, 0, 0, 0, 3'b010);

        // Reset during a stalled MEMRD: no writeback, back to FETCH, counter cleared.
        op = OP_LW;
        zero = 1'b0;
        push("rmrd_fetch",  S_FETCH,  S_FETCH,  1, 1, 3'b010, 0, 0);
        push("rmrd_decode", S_DECODE, S_DECODE, 1, 1, 3'b010, 0, 0);
        push("rmrd_memadr", S_MEMADR, S_MEMADR, 1, 1, 3'b010, 0, 0);
        push("rmrd_memrd",  S_MEMRD,  S_MEMRD,  0, 0, 3'b010, 0, 0);
        push("rmrd_rst",    S_MEMRD,  S_FETCH,  1, 0, 3'b010, 0, 1);
        push("rmrd_after",  S_FETCH,  S_FETCH,  1, 1, 3'b010, 0, 0);
        drain(0);

        // dut1: 16 jumps wrap a 4-bit counter; SW with mem_ready low is not stalled.
        for (int i = 0; i < 16; i++) run(1, "j4", OP_J, 6'b000000, 0, 0, 0, 3'b010);
        check("wrap_retired", 32'(bus1.retired), 32'd0);
        run(1, "sw_nohs", OP_SW, 6'b000000, 0, 0, 3, 3'b010);
        check("nohs_retired", 32'(bus1.retired), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
